apb_uart_bridge: RTL and testbench
==================================

APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 The block SHALL have parameter BAUD_RESET, default 650, giving the BAUD register reset value (9600 baud).
REQ-002 The block SHALL have parameter PADDR_W, default 8, giving the APB address width.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write.
- paddr  in  PADDR_W  byte address; bits [4:2] decode, others ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data, registered.
- pready  out  1  transfer complete, registered.
- pslverr  out  1  error, valid only with pready.
- baud_final_value  out  11  BAUD register to UART.
- tx_fifo_dataIn  out  8  TX byte.
- tx_fifo_writeEn  out  1  one-cycle TX push.
- tx_fifo_Full  in  1  TX FIFO full.
- rx_fifo_readEn  out  1  one-cycle RX pop.
- rx_fifo_Empty  in  1  RX FIFO empty.
- rx_fifo_dataOut  in  8  RX byte; the FIFO registers it on the clk edge that samples readEn.
- irq  out  1  level interrupt, registered.

Function
REQ-004 Register map SHALL be: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 STATUS (R/W1C), 0x0C BAUD (RW), 0x10 IEN (RW).
REQ-005 STATUS SHALL read {29'b0, tx_ovf, rx_fifo_Empty, tx_fifo_Full}; tx_ovf is sticky and cleared by writing 1 to bit 2.
REQ-006 The FSM SHALL have states IDLE, RXPOP, RXWAIT and RESP.
REQ-007 In IDLE with psel&penable&~pready: a non-empty RXDATA read SHALL go to RXPOP; every other access SHALL execute and go to RESP.
REQ-008 In RXPOP, rx_fifo_readEn SHALL be 1 for exactly one cycle; RXPOP SHALL go to RXWAIT.
REQ-009 At the end of RXWAIT, prdata SHALL capture {24'b0, rx_fifo_dataOut}; RXWAIT SHALL go to RESP.
REQ-010 In RESP, pready SHALL be 1 for exactly one cycle; RESP SHALL go to IDLE.
REQ-011 Latency SHALL be one wait state for register accesses and three wait states for a non-empty RXDATA read.
REQ-012 A TXDATA write with tx_fifo_Full=0 SHALL drive tx_fifo_dataIn=pwdata[7:0] with tx_fifo_writeEn=1 during the RESP cycle only.
REQ-013 A TXDATA write with tx_fifo_Full=1 SHALL give no push, set tx_ovf and assert pslverr.
REQ-014 An RXDATA read with rx_fifo_Empty=1 SHALL give no pop, prdata=0 and pslverr=1.
REQ-015 A BAUD write SHALL load pwdata[10:0]; a write of 0 SHALL be rejected with pslverr=1 and the register unchanged.
REQ-016 Unmapped addresses, writes to RXDATA and reads of TXDATA SHALL return pslverr=1 and prdata=0 with no side effects.
REQ-017 prdata SHALL be 0 whenever pready=0.
REQ-018 Deassertion of psel during RXPOP or RXWAIT SHALL NOT abort the pop; the FSM SHALL complete through RESP and discard the data.

Reset
REQ-019 Reset SHALL force: FSM=IDLE, pready=0, pslverr=0, prdata=0, tx_fifo_writeEn=0, rx_fifo_readEn=0, tx_fifo_dataIn=0, BAUD=BAUD_RESET, IEN=0, tx_ovf=0, irq=0.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no FIFO strobe after reset asserts.

Configuration
REQ-021 With APB_UART_IRQ_EN defined, IEN[2:0] SHALL be implemented and irq SHALL be the registered value of (IEN[0]&~rx_fifo_Empty)|(IEN[1]&~tx_fifo_Full)|(IEN[2]&tx_ovf).
REQ-022 Without APB_UART_IRQ_EN, irq SHALL be tied to 0 and address 0x10 SHALL decode as unmapped.

Verification
REQ-023 Reset, then read BAUD -> prdata=650 after 1 wait state, pslverr=0.
REQ-024 Write 0x41 to TXDATA with Full=0 -> exactly one writeEn pulse with dataIn=0x41, coincident with pready.
REQ-025 Write 0x55 to TXDATA with Full=1 -> no writeEn, pslverr=1, STATUS reads 0x4 (with Empty=0); writing 0x4 to STATUS -> reads 0x0.
REQ-026 Read RXDATA with FIFO holding 0xA5 -> single readEn pulse, prdata=0xA5 after 3 wait states; read again with Empty=1 -> prdata=0, pslverr=1, no readEn.
REQ-027 Write 0 to BAUD -> pslverr=1, BAUD stays 650; write 0x28A -> baud_final_value=650.
REQ-028 With APB_UART_IRQ_EN, set IEN=1 and drive Empty 1->0 -> irq rises one cycle later; assert reset during RXWAIT -> pready, readEn and irq all 0 immediately.

Source files
------------

// File: rtl/apb_uart_bridge.sv
// APB slave register bank in front of a UART: TX/RX FIFO strobes, sticky TX overflow, baud divisor.
// Define APB_UART_IRQ_EN to implement the IEN register at 0x10 and the level interrupt on irq.
module apb_uart_bridge #(
    parameter int BAUD_RESET = 650,
    parameter int PADDR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [PADDR_W-1:0] paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [10:0]        baud_final_value,
    output logic [7:0]         tx_fifo_dataIn,
    output logic               tx_fifo_writeEn,
    input  logic               tx_fifo_Full,
    output logic               rx_fifo_readEn,
    input  logic               rx_fifo_Empty,
    input  logic [7:0]         rx_fifo_dataOut,
    output logic               irq
);

    // APB handshake: a transfer is taken when psel & penable are high in IDLE; the
    // slave answers with a single registered pready cycle, pslverr/prdata valid only then.
    typedef enum logic [1:0] {IDLE, RXPOP, RXWAIT, RESP} state_t;

    localparam logic [2:0] SEL_TXDATA = 3'd0;
    localparam logic [2:0] SEL_RXDATA = 3'd1;
    localparam logic [2:0] SEL_STATUS = 3'd2;
    localparam logic [2:0] SEL_BAUD   = 3'd3;
    localparam logic [2:0] SEL_IEN    = 3'd4;

    state_t      state;
    logic [10:0] baud;
    logic        tx_ovf;
    logic [2:0]  sel;
    logic        access;

    logic [31:0] rd_val;
    logic        acc_err;
    logic        rx_pop;
    logic        push;
    logic        set_ovf;
    logic        clr_ovf;
    logic        baud_we;
    logic        ien_we;

    assign sel              = paddr[4:2];
    assign access           = psel & penable & ~pready;
    assign baud_final_value = baud;

`ifdef APB_UART_IRQ_EN
    logic [2:0] ien;
`endif

    // Access decode; every path not explicitly accepted falls through as an error with prdata 0.
    always_comb begin
        rd_val  = '0;
        acc_err = 1'b1;
        rx_pop  = 1'b0;
        push    = 1'b0;
        set_ovf = 1'b0;
        clr_ovf = 1'b0;
        baud_we = 1'b0;
        ien_we  = 1'b0;
        case (sel)
            SEL_TXDATA: begin
                if (pwrite) begin
                    if (tx_fifo_Full) begin
                        set_ovf = 1'b1;
                    end else begin
                        push    = 1'b1;
                        acc_err = 1'b0;
                    end
                end
            end
            SEL_RXDATA: begin
                if (!pwrite && !rx_fifo_Empty) begin
                    rx_pop  = 1'b1;
                    acc_err = 1'b0;
                end
            end
            SEL_STATUS: begin
                acc_err = 1'b0;
                if (pwrite) clr_ovf = pwdata[2];
                else        rd_val  = {29'b0, tx_ovf, rx_fifo_Empty, tx_fifo_Full};
            end
            SEL_BAUD: begin
                if (!pwrite) begin
                    rd_val  = {21'b0, baud};
                    acc_err = 1'b0;
                end else if (pwdata[10:0] != 11'd0) begin
                    baud_we = 1'b1;
                    acc_err = 1'b0;
                end
            end
`ifdef APB_UART_IRQ_EN
            SEL_IEN: begin
                acc_err = 1'b0;
                if (pwrite) ien_we = 1'b1;
                else        rd_val = {29'b0, ien};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pready          <= 1'b0;
            pslverr         <= 1'b0;
            prdata          <= '0;
            tx_fifo_writeEn <= 1'b0;
            rx_fifo_readEn  <= 1'b0;
            tx_fifo_dataIn  <= '0;
            baud            <= 11'(BAUD_RESET);
            tx_ovf          <= 1'b0;
        end else begin
            tx_fifo_writeEn <= 1'b0;
            rx_fifo_readEn  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (rx_pop) begin
                            state          <= RXPOP;
                            rx_fifo_readEn <= 1'b1;
                        end else begin
                            state           <= RESP;
                            pready          <= 1'b1;
                            pslverr         <= acc_err;
                            prdata          <= rd_val;
                            tx_fifo_writeEn <= push;
                            if (push)         tx_fifo_dataIn <= pwdata[7:0];
                            if (set_ovf)      tx_ovf <= 1'b1;
                            else if (clr_ovf) tx_ovf <= 1'b0;
                            if (baud_we)      baud <= pwdata[10:0];
                        end
                    end
                end
                RXPOP: state <= RXWAIT;
                // FIFO output register is valid here, one edge after the readEn pulse.
                RXWAIT: begin
                    state   <= RESP;
                    pready  <= 1'b1;
                    pslverr <= 1'b0;
                    prdata  <= {24'b0, rx_fifo_dataOut};
                end
                RESP: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APB_UART_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ien <= '0;
            irq <= 1'b0;
        end else begin
            if (state == IDLE && access && ien_we) ien <= pwdata[2:0];
            irq <= (ien[0] & ~rx_fifo_Empty) | (ien[1] & ~tx_fifo_Full) | (ien[2] & tx_ovf);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pwdata[31:11], paddr[PADDR_W-1:5], paddr[1:0]};
`else
    assign irq = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{pwdata[31:11], paddr[PADDR_W-1:5], paddr[1:0], ien_we, SEL_IEN};
`endif

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed and randomized APB accesses to apb_uart_bridge, checked against a register-level model.
module tb_apb_uart_bridge;

`ifdef APB_UART_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [10:0] baud_final_value;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn;
    logic        tx_fifo_Full;
    logic        rx_fifo_readEn;
    logic        rx_fifo_Empty;
    logic [7:0]  rx_fifo_dataOut = 8'h00;
    logic        irq;

    apb_uart_bridge dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .baud_final_value(baud_final_value), .tx_fifo_dataIn(tx_fifo_dataIn),
        .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_Full(tx_fifo_Full),
        .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty),
        .rx_fifo_dataOut(rx_fifo_dataOut), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe monitors and the RX FIFO's output register.
    int         push_cnt = 0, pop_cnt = 0, push_bad = 0, prdata_bad = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (tx_fifo_writeEn === 1'b1) begin
            push_cnt++;
            last_tx = tx_fifo_dataIn;
            if (pready !== 1'b1) push_bad++;
        end
        if (rx_fifo_readEn === 1'b1) pop_cnt++;
        if (pready !== 1'b1 && prdata !== 32'd0) prdata_bad++;
    end

    always @(posedge clk) if (rx_fifo_readEn === 1'b1) rx_fifo_dataOut <= rx_byte;

    // Register-level model state.
    logic [10:0] m_baud;
    logic        m_ovf;
    logic [2:0]  m_ien;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (pready !== 1'b1 && waits < 10) begin
            waits++;
            @(posedge clk); #1;
        end
        check("pready_seen", {31'b0, pready}, 32'd1);
        rd  = prdata;
        err = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic xfer_exp(input string tag, input logic w, input logic [7:0] a, input logic [31:0] d,
                            input logic [31:0] erd, input logic eerr, input int ew,
                            input int epush, input int epop);
        logic [31:0] rd;
        logic        err;
        int          waits, p0, q0;
        p0 = push_cnt;
        q0 = pop_cnt;
        apb_xfer(w, a, d, rd, err, waits);
        @(posedge clk); #1;
        check({tag, "_prdata"}, rd, erd);
        check({tag, "_pslverr"}, 32'(err), 32'(eerr));
        check({tag, "_waits"}, waits, ew);
        check({tag, "_push"}, push_cnt - p0, epush);
        check({tag, "_pop"}, pop_cnt - q0, epop);
        if (epush == 1) check({tag, "_txbyte"}, 32'(last_tx), 32'(d[7:0]));
    endtask

    // Expected outcome of one access from the register map rules; updates model state.
    task automatic model(input logic w, input logic [2:0] idx, input logic [31:0] d,
                         output logic [31:0] erd, output logic eerr, output int ew,
                         output int epush, output int epop);
        erd = 32'd0; eerr = 1'b1; ew = 1; epush = 0; epop = 0;
        if (idx == 3'd0 && w) begin
            if (tx_fifo_Full) m_ovf = 1'b1;
            else begin eerr = 1'b0; epush = 1; end
        end else if (idx == 3'd1 && !w && !rx_fifo_Empty) begin
            eerr = 1'b0; ew = 3; epop = 1; erd = {24'b0, rx_byte};
        end else if (idx == 3'd2) begin
            eerr = 1'b0;
            if (w) begin
                if (d[2]) m_ovf = 1'b0;
            end else begin
                erd = {29'b0, m_ovf, rx_fifo_Empty, tx_fifo_Full};
            end
        end else if (idx == 3'd3) begin
            if (!w) begin
                eerr = 1'b0; erd = 32'(m_baud);
            end else if (d[10:0] != 11'd0) begin
                eerr = 1'b0; m_baud = d[10:0];
            end
        end else if (idx == 3'd4 && IRQ_EN) begin
            eerr = 1'b0;
            if (w) m_ien = d[2:0];
            else   erd = 32'(m_ien);
        end
    endtask

    function automatic logic irq_exp();
        return IRQ_EN && ((m_ien[0] && !rx_fifo_Empty) || (m_ien[1] && !tx_fifo_Full) ||
                          (m_ien[2] && m_ovf));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd, d;
        logic        eerr, w;
        logic [2:0]  idx;
        logic [7:0]  a;
        int          ew, epush, epop, q0, p0;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 32'd0;
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1;
        m_baud = 11'd650; m_ovf = 1'b0; m_ien = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_writeen", 32'(tx_fifo_writeEn), 32'd0);
        check("rst_readen", 32'(rx_fifo_readEn), 32'd0);
        check("rst_datain", 32'(tx_fifo_dataIn), 32'd0);
        check("rst_baud", 32'(baud_final_value), 32'd650);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        xfer_exp("baud_rst_read", 1'b0, 8'h0C, 32'd0, 32'd650, 1'b0, 1, 0, 0);
        xfer_exp("tx_push", 1'b1, 8'h00, 32'h41, 32'd0, 1'b0, 1, 1, 0);

        tx_fifo_Full = 1'b1;
        xfer_exp("tx_full", 1'b1, 8'h00, 32'h55, 32'd0, 1'b1, 1, 0, 0);
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b0;
        xfer_exp("status_ovf", 1'b0, 8'h08, 32'd0, 32'h4, 1'b0, 1, 0, 0);
        xfer_exp("status_w1c", 1'b1, 8'h08, 32'h4, 32'd0, 1'b0, 1, 0, 0);
        xfer_exp("status_clr", 1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 1, 0, 0);

        rx_byte = 8'hA5;
        xfer_exp("rx_pop", 1'b0, 8'h04, 32'd0, 32'hA5, 1'b0, 3, 0, 1);
        rx_fifo_Empty = 1'b1;
        xfer_exp("rx_empty", 1'b0, 8'h04, 32'd0, 32'd0, 1'b1, 1, 0, 0);

        xfer_exp("baud_zero", 1'b1, 8'h0C, 32'd0, 32'd0, 1'b1, 1, 0, 0);
        check("baud_zero_kept", 32'(baud_final_value), 32'd650);
        xfer_exp("baud_123", 1'b1, 8'h0C, 32'h123, 32'd0, 1'b0, 1, 0, 0);
        check("baud_123_val", 32'(baud_final_value), 32'h123);
        xfer_exp("baud_28a", 1'b1, 8'h0C, 32'hFFFF_F28A, 32'd0, 1'b0, 1, 0, 0);
        check("baud_28a_val", 32'(baud_final_value), 32'd650);

        rx_fifo_Empty = 1'b0;
        xfer_exp("tx_read", 1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1, 0, 0);
        xfer_exp("rx_write", 1'b1, 8'h04, 32'h77, 32'd0, 1'b1, 1, 0, 0);
        xfer_exp("unmapped", 1'b1, 8'h1C, 32'hFF, 32'd0, 1'b1, 1, 0, 0);
        xfer_exp("status_side", 1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 1, 0, 0);

        // Master drops psel while the pop is in flight; the bridge still finishes the pop.
        rx_byte = 8'h3C; q0 = pop_cnt;
        @(posedge clk); #1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        check("abort_readen", 32'(rx_fifo_readEn), 32'd1);
        @(posedge clk); #1;
        check("abort_wait_pready", 32'(pready), 32'd0);
        @(posedge clk); #1;
        check("abort_resp_pready", 32'(pready), 32'd1);
        @(posedge clk); #1;
        check("abort_idle_pready", 32'(pready), 32'd0);
        check("abort_pops", pop_cnt - q0, 32'd1);
        xfer_exp("after_abort", 1'b0, 8'h0C, 32'd0, 32'd650, 1'b0, 1, 0, 0);

`ifdef APB_UART_IRQ_EN
        rx_fifo_Empty = 1'b1; tx_fifo_Full = 1'b1;
        xfer_exp("ien_w", 1'b1, 8'h10, 32'h1, 32'd0, 1'b0, 1, 0, 0);
        xfer_exp("ien_r", 1'b0, 8'h10, 32'd0, 32'h1, 1'b0, 1, 0, 0);
        check("irq_low", 32'(irq), 32'd0);
        rx_fifo_Empty = 1'b0;
        check("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'd1);
        tx_fifo_Full = 1'b0;
`else
        xfer_exp("ien_unmapped", 1'b1, 8'h10, 32'h7, 32'd0, 1'b1, 1, 0, 0);
`endif

        // Reset asserted while the read sits in RXWAIT.
        xfer_exp("baud_3ff", 1'b1, 8'h0C, 32'h3FF, 32'd0, 1'b0, 1, 0, 0);
        rx_fifo_Empty = 1'b0; rx_byte = 8'h5A; q0 = pop_cnt; p0 = push_cnt;
        @(posedge clk); #1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_readen", 32'(rx_fifo_readEn), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        check("midrst_baud", 32'(baud_final_value), 32'd650);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pops", pop_cnt - q0, 32'd1);
        check("midrst_pushes", push_cnt - p0, 32'd0);
        check("midrst_idle", 32'(pready), 32'd0);
        m_baud = 11'd650; m_ovf = 1'b0; m_ien = 3'd0;

        for (int i = 0; i < 80; i++) begin
            idx = 3'($urandom_range(0, 7));
            if (i % 4 == 0) idx = 3'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            if ($urandom_range(0, 5) == 0) d[10:0] = 11'd0;
            tx_fifo_Full  = 1'($urandom_range(0, 1));
            rx_fifo_Empty = 1'($urandom_range(0, 1));
            rx_byte       = 8'($urandom_range(0, 255));
            a = {3'($urandom_range(0, 7)), idx, 2'($urandom_range(0, 3))};
            model(w, idx, d, erd, eerr, ew, epush, epop);
            xfer_exp("rand", w, a, d, erd, eerr, ew, epush, epop);
            check("rand_baud", 32'(baud_final_value), 32'(m_baud));
            check("rand_irq", 32'(irq), 32'(irq_exp()));
        end

        check("push_outside_pready", push_bad, 32'd0);
        check("prdata_without_pready", prdata_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
